ip_sequencer: RTL and testbench

- Parametrised instruction-pointer unit for the MiniAlu family of cores.
- Replaces the single-level return register with a return-address stack of configurable depth, so CALL/RET can nest.
- Sits between the decode stage and the instruction ROM address input.
- Accepts a per-cycle redirect command and produces the registered fetch address plus stack status and error flags.

---
 rtl/ip_sequencer.sv | 141 ++++++++++++++
 tb/tb_ip_sequencer.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/ip_sequencer.sv
// Instruction-pointer unit with a return-address stack for nested CALL/RET; one-cycle registered update, stalls on iEnable=0.
// Optional SEQ_BRANCH_COUNT_EN adds a saturating 16-bit redirect counter (oBranchCount).
module ip_sequencer #(
  parameter int                    ADDR_WIDTH   = 16,
  parameter int                    STACK_DEPTH  = 8,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic                            Clock,
  input  logic                            Reset,
  input  logic                            iEnable,
  input  logic [1:0]                      iOp,
  input  logic                            iCond,
  input  logic [ADDR_WIDTH-1:0]           iTarget,
  input  logic                            iClearErr,
  output logic [ADDR_WIDTH-1:0]           oIP,
  output logic [$clog2(STACK_DEPTH):0]    oDepth,
  output logic                            oEmpty,
  output logic                            oFull,
  output logic                            oOverflow,
  output logic                            oUnderflow
`ifdef SEQ_BRANCH_COUNT_EN
  ,
  output logic [15:0]                     oBranchCount
`endif
);

  localparam int PW = $clog2(STACK_DEPTH);
  localparam int DW = PW + 1;

  localparam logic [1:0] OP_SEQ  = 2'b00;
  localparam logic [1:0] OP_JMP  = 2'b01;
  localparam logic [1:0] OP_CALL = 2'b10;
  localparam logic [1:0] OP_RET  = 2'b11;

  logic [ADDR_WIDTH-1:0] r_ip;
  logic [DW-1:0]         r_depth;
  logic                  r_ovf;
  logic                  r_unf;
  logic [ADDR_WIDTH-1:0] r_stack [STACK_DEPTH];

  logic [ADDR_WIDTH-1:0] w_next;
  logic [ADDR_WIDTH-1:0] w_ip_nxt;
  logic [DW-1:0]         w_depth_nxt;
  logic                  w_push;
  logic                  w_redirect;
  logic                  w_ovf_set;
  logic                  w_unf_set;
  logic                  w_empty;
  logic                  w_full;
  logic [PW-1:0]         w_push_idx;
  logic [PW-1:0]         w_pop_idx;

  assign w_next     = r_ip + 1'b1;
  assign w_empty    = (r_depth == '0);
  assign w_full     = (r_depth == DW'(STACK_DEPTH));
  assign w_push_idx = r_depth[PW-1:0];
  assign w_pop_idx  = PW'(r_depth - DW'(1));

  always_comb begin
    w_ip_nxt    = r_ip;
    w_depth_nxt = r_depth;
    w_push      = 1'b0;
    w_redirect  = 1'b0;
    w_ovf_set   = 1'b0;
    w_unf_set   = 1'b0;
    if (iEnable) begin
      unique case (iOp)
        OP_SEQ: w_ip_nxt = w_next;
        OP_JMP: begin
          w_ip_nxt   = iCond ? iTarget : w_next;
          w_redirect = iCond;
        end
        OP_CALL: begin
          if (w_full) begin
            w_ip_nxt  = w_next;
            w_ovf_set = 1'b1;
          end else begin
            w_ip_nxt    = iTarget;
            w_depth_nxt = r_depth + DW'(1);
            w_push      = 1'b1;
            w_redirect  = 1'b1;
          end
        end
        OP_RET: begin
          if (w_empty) begin
            w_ip_nxt  = w_next;
            w_unf_set = 1'b1;
          end else begin
            w_ip_nxt    = r_stack[w_pop_idx];
            w_depth_nxt = r_depth - DW'(1);
            w_redirect  = 1'b1;
          end
        end
        default: w_ip_nxt = w_next;
      endcase
    end
  end

  // A new error in the same cycle as a clear takes precedence.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_ip    <= RESET_VECTOR;
      r_depth <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      r_ip    <= w_ip_nxt;
      r_depth <= w_depth_nxt;
      r_ovf   <= w_ovf_set | (r_ovf & ~iClearErr);
      r_unf   <= w_unf_set | (r_unf & ~iClearErr);
    end
  end

  always_ff @(posedge Clock) begin
    if (w_push) r_stack[w_push_idx] <= w_next;
  end

  assign oIP        = r_ip;
  assign oDepth     = r_depth;
  assign oEmpty     = w_empty;
  assign oFull      = w_full;
  assign oOverflow  = r_ovf;
  assign oUnderflow = r_unf;

`ifdef SEQ_BRANCH_COUNT_EN
  logic [15:0] r_bcnt;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_bcnt <= '0;
    end else if (iClearErr) begin
      r_bcnt <= w_redirect ? 16'd1 : 16'd0;
    end else if (w_redirect && (r_bcnt != 16'hFFFF)) begin
      r_bcnt <= r_bcnt + 16'd1;
    end
  end

  assign oBranchCount = r_bcnt;
`endif

endmodule

// File: tb/tb_ip_sequencer.sv
// Scoreboard bench: stimulus pushes model-predicted state per clock, monitor pops and compares after each edge.
module tb_ip_sequencer;

  localparam int AW = 16;
  localparam int SD = 8;

  logic          Clock = 1'b0;
  logic          Reset = 1'b1;
  logic          iEnable = 1'b0;
  logic [1:0]    iOp = 2'b00;
  logic          iCond = 1'b0;
  logic [AW-1:0] iTarget = '0;
  logic          iClearErr = 1'b0;
  logic [AW-1:0] oIP;
  logic [3:0]    oDepth;
  logic          oEmpty, oFull, oOverflow, oUnderflow;
`ifdef SEQ_BRANCH_COUNT_EN
  logic [15:0]   oBranchCount;
`endif

  ip_sequencer #(.ADDR_WIDTH(AW), .STACK_DEPTH(SD), .RESET_VECTOR('0)) dut (
    .Clock(Clock), .Reset(Reset), .iEnable(iEnable), .iOp(iOp), .iCond(iCond),
    .iTarget(iTarget), .iClearErr(iClearErr), .oIP(oIP), .oDepth(oDepth),
    .oEmpty(oEmpty), .oFull(oFull), .oOverflow(oOverflow), .oUnderflow(oUnderflow)
`ifdef SEQ_BRANCH_COUNT_EN
    , .oBranchCount(oBranchCount)
`endif
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic [AW-1:0] ip;
    int            depth;
    bit            ovf;
    bit            unf;
    logic [15:0]   cnt;
  } exp_t;

  exp_t          exp_q[$];
  logic [AW-1:0] m_stack[$];
  logic [AW-1:0] m_ip;
  bit            m_ovf, m_unf;
  logic [15:0]   m_cnt;
  int            n_chk = 0;
  int            n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_stack.delete();
    m_ip  = '0;
    m_ovf = 0;
    m_unf = 0;
    m_cnt = '0;
  endtask

  // One clock of stimulus; the model works on the abstract stack queue.
  task automatic drive(input bit en, input logic [1:0] op, input bit cond,
                       input logic [AW-1:0] tgt, input bit clr);
    logic [AW-1:0] nxt;
    bit redir, onew, unew;
    exp_t e;
    @(negedge Clock);
    iEnable = en; iOp = op; iCond = cond; iTarget = tgt; iClearErr = clr;
    nxt = m_ip + 1'b1;
    redir = 0; onew = 0; unew = 0;
    if (en) begin
      case (op)
        2'b00: m_ip = nxt;
        2'b01: begin m_ip = cond ? tgt : nxt; redir = cond; end
        2'b10: begin
          if (m_stack.size() < SD) begin m_stack.push_back(nxt); m_ip = tgt; redir = 1; end
          else begin m_ip = nxt; onew = 1; end
        end
        default: begin
          if (m_stack.size() > 0) begin m_ip = m_stack.pop_back(); redir = 1; end
          else begin m_ip = nxt; unew = 1; end
        end
      endcase
    end
    m_ovf = onew | (m_ovf & !clr);
    m_unf = unew | (m_unf & !clr);
    if (clr) m_cnt = redir ? 16'd1 : 16'd0;
    else if (redir && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    e.ip = m_ip; e.depth = m_stack.size(); e.ovf = m_ovf; e.unf = m_unf; e.cnt = m_cnt;
    exp_q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge Clock);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("oIP", 32'(oIP), 32'(e.ip));
        chk("oDepth", 32'(oDepth), 32'(e.depth));
        chk("oEmpty", 32'(oEmpty), 32'(e.depth == 0));
        chk("oFull", 32'(oFull), 32'(e.depth == SD));
        chk("oOverflow", 32'(oOverflow), 32'(e.ovf));
        chk("oUnderflow", 32'(oUnderflow), 32'(e.unf));
`ifdef SEQ_BRANCH_COUNT_EN
        chk("oBranchCount", 32'(oBranchCount), 32'(e.cnt));
`endif
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    model_reset();
    #12;
    chk("reset_oIP", 32'(oIP), 32'h0);
    chk("reset_oDepth", 32'(oDepth), 32'h0);
    chk("reset_oEmpty", 32'(oEmpty), 32'h1);
    chk("reset_flags", {30'b0, oOverflow, oUnderflow}, 32'h0);
    @(negedge Clock);
    Reset = 1'b0;

    repeat (5) drive(1, 2'b00, 0, '0, 0);
    // Asynchronous reset between edges with state present.
    drive(1, 2'b10, 0, 16'h0003, 0);
    @(negedge Clock);
    iEnable = 1'b0;
    #2 Reset = 1'b1;
    #1;
    chk("async_rst_oIP", 32'(oIP), 32'h0);
    chk("async_rst_oDepth", 32'(oDepth), 32'h0);
    model_reset();
    @(negedge Clock);
    Reset = 1'b0;

    drive(1, 2'b00, 0, '0, 0);
    drive(1, 2'b00, 0, '0, 0);
    drive(1, 2'b01, 1, 16'h0040, 0);
    drive(1, 2'b01, 0, 16'h0080, 0);

    drive(1, 2'b01, 1, 16'h0005, 0);
    drive(1, 2'b10, 0, 16'h0100, 0);
    drive(1, 2'b10, 0, 16'h0200, 0);
    drive(1, 2'b11, 0, '0, 0);
    drive(1, 2'b11, 0, '0, 0);

    for (int i = 0; i < SD; i++) drive(1, 2'b10, 0, 16'(16'h1000 + i * 16'h10), 0);
    drive(1, 2'b10, 0, 16'h0300, 0);
    for (int i = 0; i < SD; i++) drive(1, 2'b11, 0, '0, 0);

    drive(1, 2'b01, 1, 16'h0010, 1);
    drive(1, 2'b11, 0, '0, 0);
    drive(1, 2'b00, 0, '0, 1);
    drive(1, 2'b11, 0, '0, 1);

    drive(1, 2'b10, 0, 16'h0500, 0);
    repeat (3) drive(0, 2'b10, 0, 16'h0777, 0);
    drive(1, 2'b11, 0, '0, 0);

    drive(1, 2'b01, 1, 16'hFFFF, 0);
    drive(1, 2'b00, 0, '0, 0);

    drive(1, 2'b00, 0, '0, 1);
    drive(1, 2'b01, 1, 16'h0020, 0);
    drive(1, 2'b10, 0, 16'h0030, 0);
    drive(1, 2'b11, 0, '0, 0);

    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 9) != 0), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            16'($urandom), ($urandom_range(0, 15) == 0));
    end

    repeat (3) @(negedge Clock);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
